// File: rtl/pe_act_queue_if.sv
// Handshake and status bundle between the broadcast network (master side)
// and a per-PE activation queue (slave side).
interface pe_act_queue_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int QW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(DEPTH + 1);

  logic          push_valid;
  logic [QW-1:0] push_data;
  logic          push_ready;
  logic          pop_act;
  logic [QW-1:0] act_out;
  logic          queue_empty;
  logic          queue_empty_next;
  logic          queue_full;
  logic          queue_afull;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] term_cnt;
  logic          underflow_err;
  logic          err_clr;

  // Producer/consumer view: drives pushes, pops and error clear.
  modport master (
    output push_valid, push_data, pop_act, err_clr,
    input  push_ready, act_out, queue_empty, queue_empty_next, queue_full,
           queue_afull, occupancy, term_cnt, underflow_err
  );

  // Queue view: accepts pushes and pops, reports status.
  modport slave (
    input  push_valid, push_data, pop_act, err_clr,
    output push_ready, act_out, queue_empty, queue_empty_next, queue_full,
           queue_afull, occupancy, term_cnt, underflow_err
  );
endinterface

// File: rtl/pe_act_queue.sv
// Per-PE activation queue: show-ahead FIFO of broadcast packets {idx, value}.
// An all-zero packet is an end-of-layer terminator; term_cnt tracks how many
// are held. queue_empty_next lets the PE FSM pop and pick its next state in
// the same cycle without waiting for the occupancy register to update.
module pe_act_queue #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic           clk,
  input  logic           rst,
  pe_act_queue_if.slave  bus
);
  localparam int QW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [QW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_termCnt;
  logic          r_underflowErr;

  logic          w_empty;
  logic          w_full;
  logic          w_pushAcc;
  logic          w_popAcc;
  logic [QW-1:0] w_head;
  logic          w_headIsTerm;
  logic          w_pushIsTerm;
  logic [CW-1:0] w_occNext;

  // Status is decoded from registered occupancy only, so push_ready never
  // depends on pop_act (no pop-to-push bypass when full).
  assign w_empty      = (r_occ == '0);
  assign w_full       = (r_occ == CW'(DEPTH));
  assign w_pushAcc    = bus.push_valid & ~w_full;
  assign w_popAcc     = bus.pop_act & ~w_empty;
  assign w_head       = r_mem[r_rdPtr];
  assign w_headIsTerm = (w_head == '0);
  assign w_pushIsTerm = (bus.push_data == '0);
  assign w_occNext    = r_occ + CW'(w_pushAcc) - CW'(w_popAcc);

  assign bus.push_ready       = ~w_full;
  assign bus.queue_empty      = w_empty;
  assign bus.queue_full       = w_full;
  assign bus.queue_afull      = (r_occ >= CW'(AFULL_THRESH));
  assign bus.queue_empty_next = (w_occNext == '0);
  assign bus.occupancy        = r_occ;
  assign bus.term_cnt         = r_termCnt;
  assign bus.underflow_err    = r_underflowErr;
  // Gate the head so stale storage never leaks out while empty.
  assign bus.act_out          = w_empty ? '0 : w_head;

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_pushAcc) begin
      r_mem[r_wrPtr] <= bus.push_data;
    end
  end

  // Read/write pointers, wrapping at DEPTH-1 so DEPTH need not be a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
    end else begin
      if (w_pushAcc) begin
        r_wrPtr <= (r_wrPtr == PW'(DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_popAcc) begin
        r_rdPtr <= (r_rdPtr == PW'(DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
      end
    end
  end

  // Occupancy follows the same next value that drives queue_empty_next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else begin
      r_occ <= w_occNext;
    end
  end

  // Terminator count: accepted zero push adds one, popping a zero head removes one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_termCnt <= '0;
    end else begin
      case ({w_pushAcc & w_pushIsTerm, w_popAcc & w_headIsTerm})
        2'b10:   r_termCnt <= r_termCnt + 1'b1;
        2'b01:   r_termCnt <= r_termCnt - 1'b1;
        default: r_termCnt <= r_termCnt;
      endcase
    end
  end

  // Sticky underflow flag; a fresh underflow outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underflowErr <= 1'b0;
    end else if (bus.pop_act & w_empty) begin
      r_underflowErr <= 1'b1;
    end else if (bus.err_clr) begin
      r_underflowErr <= 1'b0;
    end
  end
endmodule
